// File: rtl/chan_accum_adder.sv
// Registered multi-channel adder/accumulator with valid/ready streaming on
// both sides, four operation modes and optional saturating arithmetic.
module chan_accum_adder #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SAT      = 1,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [CW-1:0]    in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CW-1:0]    out_ch
);

  // Handshake: a beat transfers on in_valid & in_ready; a result transfers
  // on out_valid & out_ready. A held result never changes until taken.
  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_ACC = 2'b01,
    MODE_SUB = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam bit SAT_EN = (SAT != 0);

  logic [WIDTH-1:0] acc_q [CHANNELS];
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q, res_d;
  logic             out_ovf_q, ovf_d;
  logic [CW-1:0]    out_ch_q, ch_sel;
  logic             accept;
  logic             acc_we;
  logic [WIDTH-1:0] acc_sel;
  logic [WIDTH:0]   sum_ab, sum_acc, diff_ab;

  // With one channel the select input carries no information.
  assign ch_sel  = (CHANNELS == 1) ? '0 : in_ch;
  assign acc_sel = acc_q[ch_sel];

  assign in_ready = ena & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  assign sum_ab  = {1'b0, in_a} + {1'b0, in_b};
  assign sum_acc = {1'b0, acc_sel} + {1'b0, in_a};
  assign diff_ab = {1'b0, in_a} - {1'b0, in_b};

  always_comb begin
    res_d  = '0;
    ovf_d  = 1'b0;
    acc_we = 1'b0;
    case (mode_e'(in_mode))
      MODE_ADD: begin
        ovf_d = sum_ab[WIDTH];
        res_d = (SAT_EN && ovf_d) ? '1 : sum_ab[WIDTH-1:0];
      end
      MODE_ACC: begin
        ovf_d  = sum_acc[WIDTH];
        res_d  = (SAT_EN && ovf_d) ? '1 : sum_acc[WIDTH-1:0];
        acc_we = 1'b1;
      end
      MODE_SUB: begin
        ovf_d = diff_ab[WIDTH];
        res_d = (SAT_EN && ovf_d) ? '0 : diff_ab[WIDTH-1:0];
      end
      MODE_CLR: begin
        acc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulators update at the same edge as the result, so a same-channel
  // beat on the following cycle already reads the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_ch_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
    end else if (ena) begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res_d;
        out_ovf_q   <= ovf_d;
        out_ch_q    <= ch_sel;
        if (acc_we) acc_q[ch_sel] <= res_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_chan_accum_adder.sv
// Directed bench for chan_accum_adder: a saturating and a wrapping instance
// share one input stream; results are checked against hand-computed values.
module tb_chan_accum_adder;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n, ena, in_valid, out_ready;
  logic [W-1:0]  in_a, in_b;
  logic [1:0]    in_mode;
  logic [CW-1:0] in_ch;

  logic          in_ready, out_valid, out_ovf;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_ch;
  logic          w_in_ready, w_out_valid, w_out_ovf;
  logic [W-1:0]  w_out_data;
  logic [CW-1:0] w_out_ch;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] ADD = 2'b00, ACC = 2'b01, SUB = 2'b10, CLR = 2'b11;

  chan_accum_adder #(.WIDTH(W), .CHANNELS(4), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_ch(out_ch)
  );

  chan_accum_adder #(.WIDTH(W), .CHANNELS(4), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_ch(in_ch),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .out_ovf(w_out_ovf), .out_ch(w_out_ch)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One beat offered for exactly one edge; outputs sampled 1ns after it.
  task automatic send(input logic [1:0] mode, input logic [CW-1:0] ch,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = mode;
    in_ch    = ch;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] data,
                            input logic ovf, input logic [CW-1:0] ch);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"},  32'(out_data), 32'(data));
    check({tag, ".ovf"},   32'(out_ovf), 32'(ovf));
    check({tag, ".ch"},    32'(out_ch), 32'(ch));
  endtask

  task automatic expect_wrap(input string tag, input logic [W-1:0] data, input logic ovf);
    check({tag, ".wdata"}, 32'(w_out_data), 32'(data));
    check({tag, ".wovf"},  32'(w_out_ovf), 32'(ovf));
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_mode = ADD; in_ch = '0;
    #12;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.data",  32'(out_data), 32'd0);
    check("rst.ovf",   32'(out_ovf), 32'd0);
    check("rst.ch",    32'(out_ch), 32'd0);
    check("rst.ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    send(ADD, 2'd0, 8'd3, 8'd5);     expect_out("add", 8'd8, 1'b0, 2'd0);
    send(ADD, 2'd0, 8'd200, 8'd100); expect_out("add_sat", 8'd255, 1'b1, 2'd0);
    expect_wrap("add_wrap", 8'd44, 1'b1);
    send(SUB, 2'd0, 8'd5, 8'd9);     expect_out("sub_sat", 8'd0, 1'b1, 2'd0);
    expect_wrap("sub_wrap", 8'd252, 1'b1);
    send(SUB, 2'd1, 8'd9, 8'd5);     expect_out("sub", 8'd4, 1'b0, 2'd1);

    // channel isolation and back-to-back accumulation
    send(ACC, 2'd1, 8'd10, 8'd99);   expect_out("acc1a", 8'd10, 1'b0, 2'd1);
    send(ACC, 2'd1, 8'd20, 8'd0);    expect_out("acc1b", 8'd30, 1'b0, 2'd1);
    send(ACC, 2'd2, 8'd7, 8'd0);     expect_out("acc2", 8'd7, 1'b0, 2'd2);
    send(CLR, 2'd1, 8'd55, 8'd0);    expect_out("clr1", 8'd0, 1'b0, 2'd1);
    send(ACC, 2'd1, 8'd1, 8'd0);     expect_out("acc1c", 8'd1, 1'b0, 2'd1);
    send(ACC, 2'd0, 8'd5, 8'd0);     expect_out("acc0", 8'd5, 1'b0, 2'd0);

    // saturated accumulator sticks at max until cleared
    send(ACC, 2'd3, 8'd200, 8'd0);   expect_out("acc3a", 8'd200, 1'b0, 2'd3);
    send(ACC, 2'd3, 8'd100, 8'd0);   expect_out("acc3b", 8'd255, 1'b1, 2'd3);
    expect_wrap("acc3b_wrap", 8'd44, 1'b1);
    send(ACC, 2'd3, 8'd1, 8'd0);     expect_out("acc3c", 8'd255, 1'b1, 2'd3);
    expect_wrap("acc3c_wrap", 8'd45, 1'b0);
    send(CLR, 2'd3, 8'd0, 8'd0);     expect_out("clr3", 8'd0, 1'b0, 2'd3);

    // backpressure: result held, nothing accepted
    send(ADD, 2'd2, 8'd40, 8'd2);    expect_out("bp0", 8'd42, 1'b0, 2'd2);
    out_ready = 1'b0;
    #1;
    check("bp.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = ADD; in_ch = 2'd0;
      in_a = 8'(i * 17 + 3); in_b = 8'd1;
      @(posedge clk); #1;
      expect_out("bp.hold", 8'd42, 1'b0, 2'd2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = ADD; in_ch = 2'd1; in_a = 8'd1; in_b = 8'd1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("bp.new", 8'd2, 1'b0, 2'd1);
    @(posedge clk); #1;
    check("drain.valid", 32'(out_valid), 32'd0);
    check("drain.data",  32'(out_data), 32'd2);

    // enable low freezes a pending result and the accumulators
    send(ADD, 2'd0, 8'd7, 8'd8);     expect_out("ena0", 8'd15, 1'b0, 2'd0);
    ena = 1'b0;
    in_valid = 1'b1; in_mode = ACC; in_ch = 2'd0; in_a = 8'd9; in_b = 8'd0;
    #1;
    check("ena.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_out("ena.hold", 8'd15, 1'b0, 2'd0);
    end
    @(negedge clk);
    ena = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("ena.drain", 32'(out_valid), 32'd0);
    send(ACC, 2'd0, 8'd0, 8'd0);     expect_out("ena.acc0", 8'd5, 1'b0, 2'd0);

    // asynchronous reset between edges
    send(ACC, 2'd0, 8'd45, 8'd0);    expect_out("pre_rst", 8'd50, 1'b0, 2'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.data",  32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(ACC, 2'd0, 8'd1, 8'd0);     expect_out("post_rst", 8'd1, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chan_accum_adder.md
Name: chan_accum_adder

Overview:
- Parametrised, registered successor to the combinational 8-bit pin adder in the tile top level.
- Provides CHANNELS independent accumulators with four operation modes and optional saturation.
- A valid/ready handshake on both sides lets the tile wrapper, or a future sequencer, stream operands through it.
- Sits between the tile's ui_in/uio_in pin decode and the uo_out pin mux.

Parameters:
- WIDTH, 8, operand, accumulator and result width in bits (≥2).
- CHANNELS, 4, number of independent accumulators (power of two, ≥1).
- SAT, 1, 1 = saturating arithmetic; 0 = modular wrap.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; low freezes all state.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_mode  in  2  00 ADD, 01 ACC, 10 SUB, 11 CLR.
- in_ch  in  CW  channel select; CW = max(1, clog2(CHANNELS)).
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_ovf  out  1  overflow/underflow occurred on this result.
- out_ch  out  CW  channel tag of the result.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_ovf=0, out_ch=0, all accumulators=0.
  - in_ready follows its equation, so it is 1 while ena=1.
- in_ready = ena & (~out_valid | out_ready), combinational.
- Accept = in_valid & in_ready.
  - On accept, the result is registered at the next rising edge; out_valid=1 from that edge (latency 1).
- Output hold: while out_valid & ~out_ready, out_data, out_ovf and out_ch hold stable and in_ready=0.
- Back-to-back: when out_valid & out_ready & accept occur in the same cycle, the new result replaces the old one with no bubble. Full throughput is 1 beat/cycle.
- Drain: when out_valid & out_ready & ~accept, out_valid drops to 0 at the next edge; out_data keeps its last value.
- ena=0: no accept, no accumulator change, out_valid unchanged. A pending output stays pending even if out_ready is high.
- Arithmetic: computed at WIDTH+1 bits; carry = bit WIDTH.
  - ADD: r = a + b; ovf = carry.
  - ACC: r = acc[in_ch] + a; ovf = carry; acc[in_ch] <= final r (after saturation/wrap). in_b is ignored.
  - SUB: r = a − b; ovf = (a < b) unsigned borrow.
  - CLR: acc[in_ch] <= 0; r = 0; ovf = 0.
- SAT=1:
  - ADD/ACC with ovf: r = all ones.
  - SUB with ovf: r = 0.
- SAT=0: r = low WIDTH bits (wrap). ovf is still reported.
- Only ACC and CLR write accumulators. ADD and SUB leave all accumulators untouched.
- A saturated accumulator stays at max on further ACC beats, each with ovf=1, until CLR.
- in_ch ≥ CHANNELS cannot occur for power-of-two CHANNELS. With CHANNELS=1, in_ch is ignored and out_ch=0.
- Same-channel beats on consecutive cycles must see the accumulator value written by the previous beat. No hazard stall is allowed.
- Reset mid-operation: a pending result is discarded, out_valid=0 immediately (async), and accumulators clear.

Test Plan:
- Reset, ADD: hold rst_n=0, then release; in_valid=1, ADD a=3 b=5 ch=0 → after 1 edge, out_valid=1, out_data=8, out_ovf=0, out_ch=0.
- Saturation: ADD a=200 b=100, SAT=1 → out_data=255, ovf=1. Same beat with SAT=0 → out_data=44, ovf=1. SUB a=5 b=9 → SAT=1 gives 0/ovf=1; SAT=0 gives 252/ovf=1.
- Channel isolation and forwarding: ACC ch1 a=10, ACC ch1 a=20, ACC ch2 a=7 on consecutive cycles with out_ready=1 → outputs 10, 30, 7 with tags 1, 1, 2. Then CLR ch1 → 0. Then ACC ch1 a=1 → 1.
- Backpressure: out_ready=0 after one result 42 → in_ready=0, out_data stays 42 for 5 cycles while the in_a input changes. Raise out_ready together with a new ADD 1+1 → next edge out_data=2, no beat lost or duplicated.
- ena low: out_valid=1 pending and ena=0 with out_ready=1 for 3 cycles → out_valid stays 1 and in_ready=0. ACC beats offered meanwhile do not change acc.
- Async reset mid-stream: assert rst_n between edges while out_valid=1 and acc[0]=50 → out_valid=0 at once. After release, ACC ch0 a=1 → 1.
